// File: rtl/array_dump_sequencer.sv
// array_dump_sequencer: captures the first VIEW_LEN elements of a packed signed
// array bus on every REPEAT-th enable strobe and streams them one element per
// beat over valid/ready, tagged with element and frame indices.
module array_dump_sequencer #(
  parameter int WIDTH    = 10,
  parameter int LEN      = 256,
  parameter int VIEW_LEN = 16,
  parameter int REPEAT   = 1,
  parameter int FRAME_W  = 16,
  parameter int IDX_W    = (VIEW_LEN > 1) ? $clog2(VIEW_LEN) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    enable,
  input  logic [LEN*WIDTH-1:0]    array_in,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [WIDTH-1:0] out_data,
  output logic [IDX_W-1:0]        out_elem_idx,
  output logic [FRAME_W-1:0]      out_frame_idx,
  output logic                    busy,
  output logic                    frame_done,
  output logic [7:0]              drop_cnt
);

  localparam int DCNT_W = (REPEAT > 1) ? $clog2(REPEAT) : 1;
  localparam logic [DCNT_W-1:0] DCNT_LAST = DCNT_W'(REPEAT - 1);
  localparam logic [IDX_W-1:0]  ELEM_LAST = IDX_W'(VIEW_LEN - 1);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_SEND = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [DCNT_W-1:0]       dcnt_q, dcnt_d;
  logic [IDX_W-1:0]        elem_q, elem_d;
  logic [IDX_W-1:0]        elem_nx_s;
  logic [FRAME_W-1:0]      frame_q, frame_d;
  logic [7:0]              drop_q, drop_d;
  logic signed [WIDTH-1:0] data_q, data_d;
  logic                    done_q, done_d;
  logic signed [WIDTH-1:0] snap_q [VIEW_LEN];
  logic signed [WIDTH-1:0] snap_d [VIEW_LEN];
  logic                    qual_s, acc_s, last_s, capture_s;

  assign qual_s    = enable && (dcnt_q == DCNT_LAST);
  assign acc_s     = (state_q == S_SEND) && out_ready;
  assign last_s    = acc_s && (elem_q == ELEM_LAST);
  assign elem_nx_s = elem_q + 1'b1;

  // Next-state logic: decimation, beat sequencing, drop counting and capture.
  always_comb begin
    state_d   = state_q;
    dcnt_d    = dcnt_q;
    elem_d    = elem_q;
    frame_d   = frame_q;
    drop_d    = drop_q;
    data_d    = data_q;
    done_d    = 1'b0;
    snap_d    = snap_q;
    capture_s = 1'b0;

    if (enable) begin
      if (dcnt_q == DCNT_LAST) begin
        dcnt_d = '0;
      end else begin
        dcnt_d = dcnt_q + 1'b1;
      end
    end else begin
      dcnt_d = dcnt_q;
    end

    case (state_q)
      S_IDLE: begin
        if (qual_s) begin
          capture_s = 1'b1;
        end else begin
          capture_s = 1'b0;
        end
      end
      S_SEND: begin
        if (last_s) begin
          // Final beat accepted; a coincident strobe chains the next frame.
          done_d  = 1'b1;
          frame_d = frame_q + 1'b1;
          if (qual_s) begin
            capture_s = 1'b1;
          end else begin
            state_d = S_IDLE;
            elem_d  = '0;
            data_d  = '0;
          end
        end else if (acc_s) begin
          elem_d = elem_nx_s;
          data_d = snap_q[elem_nx_s];
          if (qual_s && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
          end else begin
            drop_d = drop_q;
          end
        end else begin
          if (qual_s && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
          end else begin
            drop_d = drop_q;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        elem_d  = '0;
        data_d  = '0;
      end
    endcase

    if (capture_s) begin
      for (int m = 0; m < VIEW_LEN; m++) begin
        snap_d[m] = array_in[m*WIDTH +: WIDTH];
      end
      elem_d  = '0;
      data_d  = array_in[WIDTH-1:0];
      state_d = S_SEND;
    end else begin
      snap_d = snap_d;
    end
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      dcnt_q  <= '0;
      elem_q  <= '0;
      frame_q <= '0;
      drop_q  <= 8'd0;
      data_q  <= '0;
      done_q  <= 1'b0;
      for (int m = 0; m < VIEW_LEN; m++) begin
        snap_q[m] <= '0;
      end
    end else begin
      state_q <= state_d;
      dcnt_q  <= dcnt_d;
      elem_q  <= elem_d;
      frame_q <= frame_d;
      drop_q  <= drop_d;
      data_q  <= data_d;
      done_q  <= done_d;
      snap_q  <= snap_d;
    end
  end

  assign out_valid     = (state_q == S_SEND);
  assign busy          = (state_q == S_SEND);
  assign out_data      = data_q;
  assign out_elem_idx  = elem_q;
  assign out_frame_idx = frame_q;
  assign frame_done    = done_q;
  assign drop_cnt      = drop_q;

endmodule
